// File: rtl/dcm_ps_driver_pkg.sv
// Shared types and constants for the DCM dynamic phase-shift driver.
// State encodings, counter/position widths and the saturating position step.
package dcm_ps_driver_pkg;

  localparam int unsigned PS_CNT_W  = 7;
  localparam int unsigned PS_POS_W  = 9;
  localparam int unsigned GAP_CNT_W = 4;
  localparam int unsigned TMO_CNT_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } ps_state_t;

  // Request latched at acceptance: direction plus steps still to execute.
  typedef struct packed {
    logic                dir;
    logic [PS_CNT_W-1:0] remaining;
  } ps_req_t;

  localparam logic signed [PS_POS_W-1:0] POS_ONE = PS_POS_W'(1);

  // One step of the net phase position, clamped to +/-lim.
  function automatic logic signed [PS_POS_W-1:0] ps_pos_step(
    input logic signed [PS_POS_W-1:0] pos,
    input logic                       dir,
    input logic signed [PS_POS_W-1:0] lim
  );
    logic signed [PS_POS_W-1:0] res;
    res = pos;
    if (dir) begin
      if (pos < lim) res = pos + POS_ONE;
    end else begin
      if (pos > -lim) res = pos - POS_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/dcm_ps_driver_timeout.sv
// PSDONE watchdog for dcm_ps_driver; only built when PS_TIMEOUT_EN is defined.
// Counts enabled cycles since the last clear and flags when TMO cycles have elapsed.
`ifdef PS_TIMEOUT_EN
module ps_timeout_cnt
  import dcm_ps_driver_pkg::*;
#(
  parameter int unsigned TMO = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TMO_CNT_W'(1);
    end
  end

  // High during the TMO-th enabled cycle so the FSM can leave on that edge.
  assign expired = en && (cnt == TMO_CNT_W'(TMO - 1));

endmodule
`endif

// File: rtl/dcm_ps_driver.sv
// Drives the DCM dynamic phase-shift port one step at a time for the sync controller.
// Optional PSDONE watchdog is enabled by defining PS_TIMEOUT_EN.
module dcm_ps_driver
  import dcm_ps_driver_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned PS_MAX     = 255
`ifdef PS_TIMEOUT_EN
  ,
  parameter int unsigned PSDONE_TMO = 1023
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adj,
  input  logic                       inc_dec,
  input  logic [PS_CNT_W-1:0]        ps_cycles,
  input  logic                       dcm_locked,
  input  logic                       dcm_psdone,
  output logic                       dcm_psen,
  output logic                       dcm_psincdec,
  output logic                       psen,
  output logic                       ps_end,
  output logic                       busy,
  output logic signed [PS_POS_W-1:0] ps_pos,
  output logic                       err
);

  localparam logic signed [PS_POS_W-1:0] POS_LIM   = PS_POS_W'(PS_MAX);
  localparam logic [GAP_CNT_W-1:0]       GAP_RELOAD = GAP_CNT_W'(GAP_CYCLES - 1);

  ps_state_t            state;
  ps_req_t              req;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 tmo_expired;

`ifdef PS_TIMEOUT_EN
  ps_timeout_cnt #(
    .TMO(PSDONE_TMO)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_ISSUE),
    .en     (state == ST_WAIT),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Direction is held in the request register, so it cannot move mid-step.
  assign dcm_psincdec = req.dir;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req      <= '0;
      gap_cnt  <= '0;
      dcm_psen <= 1'b0;
      psen     <= 1'b0;
      ps_end   <= 1'b0;
      busy     <= 1'b0;
      ps_pos   <= '0;
      err      <= 1'b0;
    end else begin
      dcm_psen <= 1'b0;
      psen     <= 1'b0;
      ps_end   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (adj && dcm_locked) begin
            req.dir       <= inc_dec;
            req.remaining <= (ps_cycles == '0) ? PS_CNT_W'(1) : ps_cycles;
            state         <= ST_ISSUE;
            dcm_psen      <= 1'b1;
            psen          <= 1'b1;
            busy          <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (!dcm_locked) begin
            err    <= 1'b1;
            ps_end <= 1'b1;
            state  <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end

        // Lock loss outranks a coincident PSDONE; PSDONE outranks the watchdog.
        ST_WAIT: begin
          if (!dcm_locked) begin
            err    <= 1'b1;
            ps_end <= 1'b1;
            state  <= ST_DONE;
          end else if (dcm_psdone) begin
            req.remaining <= req.remaining - PS_CNT_W'(1);
            ps_pos        <= ps_pos_step(ps_pos, req.dir, POS_LIM);
            if (req.remaining == PS_CNT_W'(1)) begin
              ps_end <= 1'b1;
              state  <= ST_DONE;
            end else begin
              gap_cnt <= GAP_RELOAD;
              state   <= ST_GAP;
            end
          end else if (tmo_expired) begin
            err    <= 1'b1;
            ps_end <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_GAP: begin
          if (!dcm_locked) begin
            err    <= 1'b1;
            ps_end <= 1'b1;
            state  <= ST_DONE;
          end else if (gap_cnt == '0) begin
            dcm_psen <= 1'b1;
            psen     <= 1'b1;
            state    <= ST_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
